// File: rtl/time_set_ctrl.sv
// Time-setting front end: debounces mode/up/down buttons and edits hour/minute/second in
// shadow registers, then hands them to the watch counter with a one-cycle load strobe.
module time_set_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic       setting,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       set_load
);

  localparam int unsigned CntW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {StRun, StEditH, StEditM, StEditS, StCommit} state_e;

  // Button index 0 = mode, 1 = up, 2 = down.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, press;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic            mode_p, up_p, dn_p;

  state_e     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic       blink_q, blink_d;

  assign btn_raw = {btn_down, btn_up, btn_mode};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) deb_d[i] = sync2_q[i];
        else                    cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  assign press  = deb_q & ~deb_dly_q;
  assign mode_p = press[0];
  // Mode wins; simultaneous up and down cancel out.
  assign up_p   = press[1] & ~press[2] & ~mode_p;
  assign dn_p   = press[2] & ~press[1] & ~mode_p;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                           input logic inc, input logic dec);
    logic [5:0] r;
    r = v;
    if (inc)      r = (v == top)  ? 6'd0 : v + 6'd1;
    else if (dec) r = (v == 6'd0) ? top  : v - 6'd1;
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    blink_d    = 1'b0;
    setting    = 1'b1;
    edit_field = 2'd0;
    set_load   = 1'b0;
    unique case (state_q)
      StRun: begin
        setting = 1'b0;
        if (mode_p) begin
          hour_d  = cur_hour;
          min_d   = cur_minute;
          sec_d   = cur_second;
          blink_d = 1'b1;
          state_d = StEditH;
        end
      end
      StEditH: begin
        edit_field = 2'd1;
        blink_d    = blink_q ^ en_1hz;
        hour_d     = 5'(wrap_step({1'b0, hour_q}, 6'd23, up_p, dn_p));
        if (mode_p) state_d = StEditM;
      end
      StEditM: begin
        edit_field = 2'd2;
        blink_d    = blink_q ^ en_1hz;
        min_d      = wrap_step(min_q, 6'd59, up_p, dn_p);
        if (mode_p) state_d = StEditS;
      end
      StEditS: begin
        edit_field = 2'd3;
        blink_d    = blink_q ^ en_1hz;
        sec_d      = wrap_step(sec_q, 6'd59, up_p, dn_p);
        if (mode_p) state_d = StCommit;
      end
      StCommit: begin
        set_load = 1'b1;
        state_d  = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q   <= StRun;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      blink_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      blink_q   <= blink_d;
    end
  end

  assign blink      = blink_q;
  assign set_hour   = hour_q;
  assign set_minute = min_q;
  assign set_second = sec_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a short debounce window.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_1hz = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_minute = '0, cur_second = '0;
  logic       setting, blink, set_load;
  logic [1:0] edit_field;
  logic [4:0] set_hour;
  logic [5:0] set_minute, set_second;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;
  int bad_after = 0;
  logic prev_load = 1'b0;

  time_set_ctrl #(.DEB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_1hz     (en_1hz),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .cur_hour   (cur_hour),
    .cur_minute (cur_minute),
    .cur_second (cur_second),
    .setting    (setting),
    .edit_field (edit_field),
    .blink      (blink),
    .set_hour   (set_hour),
    .set_minute (set_minute),
    .set_second (set_second),
    .set_load   (set_load)
  );

  always #5 clk = ~clk;

  // Tracks load strobes and whether setting stays high after one.
  always @(negedge clk) begin
    if (prev_load && setting) bad_after++;
    if (set_load) load_cnt++;
    prev_load = set_load;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    btn_mode = m; btn_up = u; btn_down = d;
    cyc(10);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cyc(10);
  endtask

  task automatic tick;
    en_1hz = 1'b1;
    cyc(1);
    en_1hz = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    // Reset state
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_setting", setting, 0);
    check("rst_field", edit_field, 0);
    check("rst_blink", blink, 0);
    check("rst_load", set_load, 0);
    check("rst_hour", set_hour, 0);
    check("rst_min", set_minute, 0);
    check("rst_sec", set_second, 0);

    // Short glitch is filtered
    cur_hour = 5'd13; cur_minute = 6'd45; cur_second = 6'd7;
    btn_mode = 1'b1;
    cyc(2);
    btn_mode = 1'b0;
    cyc(12);
    check("glitch_field", edit_field, 0);
    check("glitch_setting", setting, 0);

    // Held press captures current time
    press(1, 0, 0);
    check("cap_field", edit_field, 1);
    check("cap_setting", setting, 1);
    check("cap_hour", set_hour, 13);
    check("cap_min", set_minute, 45);
    check("cap_sec", set_second, 7);
    check("cap_blink", blink, 1);
    tick();
    check("blink_tog0", blink, 0);
    tick();
    check("blink_tog1", blink, 1);

    // Hour and minute wrap
    do_reset();
    check("rst2_field", edit_field, 0);
    cur_hour = 5'd22; cur_minute = 6'd0; cur_second = 6'd30;
    press(1, 0, 0);
    check("h_start", set_hour, 22);
    press(0, 1, 0);
    check("h_up1", set_hour, 23);
    press(0, 1, 0);
    check("h_up2", set_hour, 0);
    press(0, 1, 0);
    check("h_up3", set_hour, 1);
    press(1, 0, 0);
    check("m_field", edit_field, 2);
    check("m_start", set_minute, 0);
    press(0, 0, 1);
    check("m_down_wrap", set_minute, 59);

    // Simultaneous events in EDIT_M
    press(0, 1, 1);
    check("updn_min", set_minute, 59);
    check("updn_field", edit_field, 2);
    press(1, 1, 0);
    check("modeup_field", edit_field, 3);
    check("modeup_min", set_minute, 59);
    check("modeup_hour", set_hour, 1);

    // Reset abandons edit
    rst = 1'b1;
    cyc(1);
    check("abort_setting", setting, 0);
    check("abort_field", edit_field, 0);
    check("abort_hour", set_hour, 0);
    check("abort_min", set_minute, 0);
    check("abort_sec", set_second, 0);
    rst = 1'b0;
    cyc(2);
    check("abort_no_load", load_cnt, 0);

    // Full edit and commit
    cur_hour = 5'd13; cur_minute = 6'd45; cur_second = 6'd7;
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    check("pre_commit_field", edit_field, 3);
    check("pre_commit_load", load_cnt, 0);
    press(1, 0, 0);
    check("commit_loads", load_cnt, 1);
    check("commit_setting_drop", bad_after, 0);
    check("commit_field", edit_field, 0);
    check("commit_setting", setting, 0);
    check("commit_blink", blink, 0);
    check("commit_hour", set_hour, 14);
    check("commit_min", set_minute, 45);
    check("commit_sec", set_second, 6);

    // Up/down in RUN ignored, shadow held
    press(0, 1, 0);
    check("run_up_hour", set_hour, 14);
    check("run_up_field", edit_field, 0);
    check("run_load_total", load_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
User time-setting front end for the digital clock. It debounces three push-buttons and walks the user through editing hour, minute and second in shadow registers. It then writes the edited time back into the watch counter with a one-cycle load strobe. It is the writer side of the time interface that the watch counter and lcd_display_string read from. It sits beside watch in digital_clock and shares clk, rst and en_1hz.

Parameters:
DEB_CYCLES, 500000, consecutive stable synchronized cycles required before a button level is accepted (10 ms at 50 MHz); minimum 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en_1hz  input  1  one-cycle 1 Hz enable from en_clk, used for blink only
btn_mode  input  1  raw mode button, active-high, asynchronous to clk
btn_up  input  1  raw increment button, active-high, asynchronous
btn_down  input  1  raw decrement button, active-high, asynchronous
cur_hour  input  5  current watch hour, 0..23
cur_minute  input  6  current watch minute, 0..59
cur_second  input  6  current watch second, 0..59
setting  output  1  high while editing or committing; watch freezes counting while high
edit_field  output  2  0=none, 1=hour, 2=minute, 3=second
blink  output  1  toggles on each en_1hz while editing, for blanking the edited field on LCD
set_hour  output  5  shadow hour, continuously driven
set_minute  output  6  shadow minute
set_second  output  6  shadow second
set_load  output  1  one-cycle strobe; watch loads set_* on this cycle

Behaviour:
- Reset (rst=1 at a clk edge):
  - state RUN; setting=0, edit_field=0, blink=0, set_load=0, set_*=0.
  - Synchronizers, debounce counters and debounced levels are cleared to 0.
  - Reset mid-edit abandons the edit; no set_load is issued.
- Button path, per button:
  - 2-flop synchronizer feeds a debounce counter.
  - The counter increments while the synchronized level differs from the debounced level, and clears when they match.
  - When the counter reaches DEB_CYCLES-1 and still differs, the debounced level takes the new value and the counter clears.
  - A press pulse is asserted for exactly 1 cycle on the cycle after the debounced level rises 0->1. Releases produce no pulse.
- Priority within one cycle: mode pulse beats up/down; up and down pulses together are both ignored.
- FSM states: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT.
  - RUN: edit_field=0. On mode pulse, capture cur_hour/cur_minute/cur_second into the shadow registers and go to EDIT_H.
  - EDIT_H: edit_field=1. Up/down pulses change the hour. A mode pulse moves to EDIT_M.
  - EDIT_M: edit_field=2. Up/down pulses change the minute. A mode pulse moves to EDIT_S.
  - EDIT_S: edit_field=3. Up/down pulses change the second. A mode pulse moves to COMMIT.
  - COMMIT: lasts exactly 1 cycle. set_load=1 and setting=1, then the FSM returns to RUN.
- Field arithmetic: modular wrap, with up/down acting on the clock edge where the pulse is high.
  - Hour: up 23->0, down 0->23.
  - Minute and second: up 59->0, down 0->59.
  - Shadow registers are held unchanged in RUN after a commit, until the next capture.
- setting=1 in EDIT_H, EDIT_M, EDIT_S and COMMIT.
- Blink:
  - Forced to 0 in RUN.
  - In edit states, blink toggles on each cycle with en_1hz=1.
  - blink is reset to 1 on entry to EDIT_H, so the field is shown immediately.
- Button activity in RUN other than mode (up/down pulses) is ignored.
- set_load never asserts except in COMMIT.

Test Plan:
- Reset with all buttons low, DEB_CYCLES=4 -> all outputs 0, edit_field=0, state RUN.
- Debounce: btn_mode glitch high for 2 cycles -> no state change. btn_mode held high for 10 cycles -> exactly one mode pulse; with cur_hour=13, cur_minute=45, cur_second=7 the block enters EDIT_H with set_hour=13, set_minute=45, set_second=7, setting=1.
- Wrap in EDIT_H:
  - Starting from set_hour=22, three up presses -> set_hour 23, 0, 1.
  - In EDIT_M from set_minute=0, one down press -> set_minute=59.
- Full sequence from RUN with cur=13:45:07: mode, up, mode, mode, down, mode ->
  - set_hour=14, set_minute=45, set_second=6;
  - set_load high for exactly one cycle;
  - setting drops the cycle after set_load;
  - edit_field returns to 0.
- Simultaneous events in EDIT_M:
  - Up and down pulses in the same cycle -> set_minute unchanged.
  - Mode and up pulses in the same cycle -> go to EDIT_S, set_minute unchanged.
- Reset asserted in EDIT_S -> next cycle in RUN, set_load never pulses, setting=0, set_*=0.
